key_expansion_multi: RTL

- Iterative AES key-schedule engine for all three FIPS-197 key sizes (128/192/256), selected per key by a mode input.
- Generates one 32-bit schedule word per clock into an internal word file.
- Exposes a per-round valid bitmap and a registered round-key read port to the cipher datapath.
- Successor to the fixed AES-128 expansion block: adds key-size modes, a ready/valid input handshake, a done pulse and indexed read-out.

---
 rtl/key_expansion_multi.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/key_expansion_multi.sv
// AES key-schedule engine for 128/192/256-bit keys.
// Each clock produces one 32-bit schedule word into an internal word file.
// The cipher datapath reads round keys back through a registered port and
// uses the per-round valid bitmap to know which keys are ready.

// Forward AES S-box: a byte-wide lookup used four times to build SubWord.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign out_byte = SBOX[in_byte];

endmodule

module key_expansion_multi #(
  parameter int KEY_LEN_MAX       = 256,
  parameter int RK_LEN            = 128,
  parameter int NUMS_OF_ROUND_MAX = 15
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [KEY_LEN_MAX-1:0]       Secret_key,
  input  logic [1:0]                   key_mode,
  input  logic                         valid_in,
  output logic                         ready_out,
  input  logic [3:0]                   rk_sel,
  output logic [RK_LEN-1:0]            rk_data,
  output logic [NUMS_OF_ROUND_MAX-1:0] valid_out,
  output logic                         done,
  output logic                         err
);

  localparam int NUM_WORDS = 4 * NUMS_OF_ROUND_MAX;

  typedef enum logic {
    IDLE,
    EXPAND
  } state_t;

  state_t state, state_next;

  logic [31:0] w_file [NUM_WORDS];

  logic [5:0] word_idx;
  logic [3:0] nk;
  logic [3:0] nr;
  logic [5:0] last_idx;
  logic [2:0] mod_cnt;
  logic [7:0] rcon;

  logic [3:0] mode_nk;
  logic [3:0] mode_nr;
  logic [5:0] mode_last;

  logic accept;
  logic reject;
  logic last_word;

  logic [31:0] prev_word;
  logic [31:0] back_word;
  logic [31:0] rot_word;
  logic [31:0] sbox_in;
  logic [31:0] sub_word;
  logic [31:0] temp_word;
  logic [31:0] new_word;
  logic [7:0]  rcon_next;
  logic [5:0]  rd_base;

  assign accept    = (state == IDLE) && valid_in && (key_mode != 2'd3);
  assign reject    = (state == IDLE) && valid_in && (key_mode == 2'd3);
  assign last_word = (state == EXPAND) && (word_idx == last_idx);
  assign ready_out = (state == IDLE);

  // Decode the requested key size into Nk, Nr and the index of the final schedule word.
  always_comb begin
    mode_nk   = 4'd4;
    mode_nr   = 4'd10;
    mode_last = 6'd43;
    case (key_mode)
      2'd1: begin
        mode_nk   = 4'd6;
        mode_nr   = 4'd12;
        mode_last = 6'd51;
      end
      2'd2: begin
        mode_nk   = 4'd8;
        mode_nr   = 4'd14;
        mode_last = 6'd59;
      end
      default: begin
        mode_nk   = 4'd4;
        mode_nr   = 4'd10;
        mode_last = 6'd43;
      end
    endcase
  end

  // State register for the idle/expand sequencer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: leave idle on an accepted key, return after the last word.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (accept)    state_next = EXPAND;
      EXPAND: if (last_word) state_next = IDLE;
    endcase
  end

  assign prev_word = w_file[word_idx - 6'd1];
  assign back_word = w_file[word_idx - {2'b00, nk}];
  assign rot_word  = {prev_word[23:0], prev_word[31:24]};
  assign sbox_in   = (mod_cnt == 3'd0) ? rot_word : prev_word;
  assign rcon_next = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
  assign rd_base   = {rk_sel, 2'b00};

  aes_sbox u_sbox3 (.in_byte(sbox_in[31:24]), .out_byte(sub_word[31:24]));
  aes_sbox u_sbox2 (.in_byte(sbox_in[23:16]), .out_byte(sub_word[23:16]));
  aes_sbox u_sbox1 (.in_byte(sbox_in[15:8]),  .out_byte(sub_word[15:8]));
  aes_sbox u_sbox0 (.in_byte(sbox_in[7:0]),   .out_byte(sub_word[7:0]));

  // Pick the transform for the current word: rotate+sub+rcon at Nk boundaries, plain sub mid-block for 256-bit keys.
  always_comb begin
    temp_word = prev_word;
    if (mod_cnt == 3'd0) begin
      temp_word = sub_word ^ {rcon, 24'h0};
    end else if ((nk == 4'd8) && (mod_cnt == 3'd4)) begin
      temp_word = sub_word;
    end
  end

  assign new_word = back_word ^ temp_word;

  // Word file, round bookkeeping, status pulses and the registered round-key read port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_WORDS; k++) begin
        w_file[k] <= 32'h0;
      end
      word_idx  <= 6'd0;
      nk        <= 4'd4;
      nr        <= 4'd0;
      last_idx  <= 6'd43;
      mod_cnt   <= 3'd0;
      rcon      <= 8'h01;
      valid_out <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      rk_data   <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;

      if (rk_sel <= nr) begin
        rk_data <= {w_file[rd_base], w_file[rd_base + 6'd1],
                    w_file[rd_base + 6'd2], w_file[rd_base + 6'd3]};
      end else begin
        rk_data <= '0;
      end

      if (accept) begin
        for (int k = 0; k < 8; k++) begin
          if (k < int'(mode_nk)) begin
            w_file[k] <= Secret_key[KEY_LEN_MAX-1-32*k -: 32];
          end
        end
        nk        <= mode_nk;
        nr        <= mode_nr;
        last_idx  <= mode_last;
        word_idx  <= {2'b00, mode_nk};
        mod_cnt   <= 3'd0;
        rcon      <= 8'h01;
        valid_out <= (key_mode == 2'd2) ? NUMS_OF_ROUND_MAX'(3) : NUMS_OF_ROUND_MAX'(1);
      end else if (reject) begin
        err <= 1'b1;
      end else if (state == EXPAND) begin
        w_file[word_idx] <= new_word;
        if (word_idx[1:0] == 2'b11) begin
          valid_out[word_idx[5:2]] <= 1'b1;
        end
        if (mod_cnt == 3'(nk - 4'd1)) begin
          mod_cnt <= 3'd0;
        end else begin
          mod_cnt <= mod_cnt + 3'd1;
        end
        if (mod_cnt == 3'd0) begin
          rcon <= rcon_next;
        end
        word_idx <= word_idx + 6'd1;
        if (last_word) begin
          done <= 1'b1;
        end
      end
    end
  end

endmodule
